score_tally: RTL

Game-level scoring stage sitting directly downstream of the per-arrow dropper modules. Collects the one-bit `score` level from every dropper lane and rising-edge detects each one, so each hit counts exactly once. Accumulates a saturating point total and hit count, gated by a small game-state machine driven by the same keycodes the droppers use. Feeds the total to the on-board seven-segment display and to the VGA overlay logic.

---
 rtl/score_tally_if.sv | 29 ++
 rtl/score_tally.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/score_tally_if.sv
// score_tally_if: keycode/lane inputs and score/status/display outputs of the score_tally stage.
// The DUT side uses the slave modport; the driver/observer side uses master.
interface score_tally_if #(
    parameter int N_LANES = 32
);
    logic [7:0]         keycode;
    logic [N_LANES-1:0] score_in;
    logic [15:0]        score_total;
    logic [11:0]        hit_count;
    logic               hit_pulse;
    logic               playing;
    logic               game_over;
    logic [6:0]         HEX0;
    logic [6:0]         HEX1;
    logic [6:0]         HEX2;
    logic [6:0]         HEX3;

    modport master (
        output keycode, score_in,
        input  score_total, hit_count, hit_pulse, playing, game_over,
        input  HEX0, HEX1, HEX2, HEX3
    );

    modport slave (
        input  keycode, score_in,
        output score_total, hit_count, hit_pulse, playing, game_over,
        output HEX0, HEX1, HEX2, HEX3
    );
endinterface

// File: rtl/score_tally.sv
// score_tally: rising-edge hit detection and saturating score/hit totals, gated by an Idle/Playing/Done game FSM.
// Define SCORE_TALLY_HEX_EN to decode score_total onto HEX0..HEX3; otherwise all digits are blanked.

`ifdef SCORE_TALLY_HEX_EN
module score_tally_hex7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end
endmodule
`endif

module score_tally #(
    parameter int N_LANES     = 32,
    parameter int POINTS      = 10,
    parameter int SONG_FRAMES = 4000
) (
    input logic          frame_clk,
    input logic          Reset,
    score_tally_if.slave bus
);
    localparam int          CNT_W      = $clog2(N_LANES + 1);
    localparam logic [11:0] LAST_FRAME = 12'(SONG_FRAMES - 1);
    localparam logic [7:0]  KEY_START  = 8'h2C;
    localparam logic [7:0]  KEY_QUIT   = 8'h01;

    typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [N_LANES-1:0] prev;
    logic [N_LANES-1:0] rise;
    logic [CNT_W-1:0]   n_rise;
    logic [11:0]        frame_cnt;
    logic [11:0]        frame_cnt_next;
    logic [15:0]        score_total_q;
    logic [15:0]        score_total_next;
    logic [11:0]        hit_count_q;
    logic [11:0]        hit_count_next;
    logic               hit_pulse_q;
    logic               hit_pulse_next;
    logic               playing_q;
    logic               game_over_q;
    logic [16:0]        total_sum;
    logic [12:0]        hits_sum;

    assign rise = bus.score_in & ~prev;

    always_comb begin
        n_rise = '0;
        for (int i = 0; i < N_LANES; i++)
            n_rise = n_rise + CNT_W'(rise[i]);
    end

    // One extra bit on each sum turns overflow into a carry that selects the clamp value.
    assign total_sum = {1'b0, score_total_q} + 17'(n_rise) * 17'(POINTS);
    assign hits_sum  = {1'b0, hit_count_q} + 13'(n_rise);

    always_comb begin
        state_next       = state;
        frame_cnt_next   = frame_cnt;
        score_total_next = score_total_q;
        hit_count_next   = hit_count_q;
        hit_pulse_next   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.keycode == KEY_START)
                    state_next = PLAYING;
            end
            PLAYING: begin
                // Quitting discards any hit arriving on the same frame.
                if (bus.keycode == KEY_QUIT) begin
                    state_next       = IDLE;
                    frame_cnt_next   = '0;
                    score_total_next = '0;
                    hit_count_next   = '0;
                end else begin
                    score_total_next = total_sum[16] ? 16'hFFFF : total_sum[15:0];
                    hit_count_next   = hits_sum[12] ? 12'hFFF : hits_sum[11:0];
                    hit_pulse_next   = (n_rise != '0);
                    frame_cnt_next   = frame_cnt + 12'd1;
                    if (frame_cnt == LAST_FRAME)
                        state_next = DONE;
                end
            end
            DONE: begin
                if (bus.keycode == KEY_QUIT) begin
                    state_next       = IDLE;
                    frame_cnt_next   = '0;
                    score_total_next = '0;
                    hit_count_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state         <= IDLE;
            prev          <= '1;
            frame_cnt     <= '0;
            score_total_q <= '0;
            hit_count_q   <= '0;
            hit_pulse_q   <= 1'b0;
            playing_q     <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state         <= state_next;
            prev          <= bus.score_in;
            frame_cnt     <= frame_cnt_next;
            score_total_q <= score_total_next;
            hit_count_q   <= hit_count_next;
            hit_pulse_q   <= hit_pulse_next;
            playing_q     <= (state_next == PLAYING);
            game_over_q   <= (state_next == DONE);
        end
    end

    assign bus.score_total = score_total_q;
    assign bus.hit_count   = hit_count_q;
    assign bus.hit_pulse   = hit_pulse_q;
    assign bus.playing     = playing_q;
    assign bus.game_over   = game_over_q;

`ifdef SCORE_TALLY_HEX_EN
    score_tally_hex7 u_hex0 (.nibble(score_total_q[3:0]),   .seg(bus.HEX0));
    score_tally_hex7 u_hex1 (.nibble(score_total_q[7:4]),   .seg(bus.HEX1));
    score_tally_hex7 u_hex2 (.nibble(score_total_q[11:8]),  .seg(bus.HEX2));
    score_tally_hex7 u_hex3 (.nibble(score_total_q[15:12]), .seg(bus.HEX3));
`else
    assign bus.HEX0 = 7'h7F;
    assign bus.HEX1 = 7'h7F;
    assign bus.HEX2 = 7'h7F;
    assign bus.HEX3 = 7'h7F;
`endif
endmodule
